pc_logic: RTL and testbench

- Program-counter register and next-PC logic for the multi-cycle RV32 CPU core.
- Holds the current instruction address and advances it once per instruction, when the control FSM pulses the enable.
- Next PC is one of three values:
  - sequential (PC+4)
  - PC-relative branch/JAL target (PC+Imm)
  - register-indirect JALR target (RS1+Imm, bit 0 cleared)
- o_PC feeds instruction fetch and the ALU/writeback paths.

---
 rtl/pc_logic.sv | 44 ++++
 tb/tb_pc_logic.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_logic.sv
// Program-counter register with next-PC selection for the multi-cycle RV32 core.
// Supports sequential, PC-relative and register-indirect (JALR) updates.
module pc_logic #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_En,
    input  logic        i_TakeBranch,
    input  logic        i_BranchSrc,
    input  logic [31:0] i_Imm,
    input  logic [31:0] i_RS1,
    output logic [31:0] o_PC
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INSN_LEN = 4;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] base_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] next_pc_c;

    // Next-PC select; only the JALR path forces the target to even alignment.
    always_comb begin
        base_c    = i_BranchSrc ? i_RS1 : pc;
        target_c  = base_c + i_Imm;
        if (i_BranchSrc) begin
            target_c[0] = 1'b0;
        end
        next_pc_c = i_TakeBranch ? target_c : (pc + XLEN'(INSN_LEN));
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            pc <= RESET_ADDR;
        end else if (i_En) begin
            pc <= next_pc_c;
        end
    end

    assign o_PC = pc;

endmodule

// File: tb/tb_pc_logic.sv
// Directed-vector bench for pc_logic: table of single-edge transactions plus
// hand-written multi-cycle sequences (long enable runs, held reset).
module tb_pc_logic;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_En;
    logic        i_TakeBranch;
    logic        i_BranchSrc;
    logic [31:0] i_Imm;
    logic [31:0] i_RS1;
    logic [31:0] o_PC;

    int total;
    int bad;

    pc_logic #(.RESET_ADDR(32'h0000_0000)) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_En         (i_En),
        .i_TakeBranch (i_TakeBranch),
        .i_BranchSrc  (i_BranchSrc),
        .i_Imm        (i_Imm),
        .i_RS1        (i_RS1),
        .o_PC         (o_PC)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        tb;
        logic        bs;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] exp_pc;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic tb, input logic bs,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] exp_pc, input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.tb = tb; v.bs = bs;
        v.imm = imm; v.rs1 = rs1; v.exp_pc = exp_pc; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: o_PC=0x%08h expected=0x%08h", name, act, exp_v);
        end
    endtask

    // Drive on the falling edge, let one rising edge happen, sample just after.
    task automatic step(input logic rst, input logic en, input logic tb, input logic bs,
                        input logic [31:0] imm, input logic [31:0] rs1);
        @(negedge i_Clk);
        i_Rst = rst; i_En = en; i_TakeBranch = tb; i_BranchSrc = bs;
        i_Imm = imm; i_RS1 = rs1;
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_Rst = 1'b0; i_En = 1'b1; i_TakeBranch = 1'b1; i_BranchSrc = 1'b0;
        i_Imm = 32'h0; i_RS1 = 32'h0;

        //    rst  en   tb   bs   imm           rs1           exp
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000, "reset_edge1");
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0040, 32'h0000_0000, "reset_edge2");
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004, "seq_4");
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0008, "seq_8");
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_000C, "seq_c");
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0040, 32'h0000_000C, "hold_1");
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_000C, "hold_2");
        add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0014, "rel_fwd");
        add(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_000C, "rel_back");
        add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0014, "rel_fwd2");
        add(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0008, 32'h0000_0010, "jalr_add");
        add(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0009, 32'h0000_0008, "jalr_lsb");
        add(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "jalr_top");
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000, "wrap");
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004, "after_wrap_4");
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0008, "after_wrap_8");
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_0000, "reset_mid");
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004, "resume_4");
        add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 32'h0,         32'h0000_0005, "rel_misalign");
        add(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_1000, 32'h0000_0009, "seq_bs_dc");
        add(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF7, 32'h0,         32'h0000_0000, "rel_neg_zero");
        add(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0102, 32'h0000_0100, "jalr_neg_odd");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].tb, vecs[i].bs, vecs[i].imm, vecs[i].rs1);
            check(vecs[i].name, o_PC, vecs[i].exp_pc);
        end

        // Enable held high for five edges: five updates from 0x100.
        for (int n = 1; n <= 5; n++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            check($sformatf("run_%0d", n), o_PC, 32'h0000_0100 + 32'(4 * n));
        end

        // Inputs changing between edges must not reach o_PC.
        i_TakeBranch = 1'b1; i_BranchSrc = 1'b1; i_RS1 = 32'h0000_8000; i_Imm = 32'h0000_0010;
        #1;
        check("no_comb_path", o_PC, 32'h0000_0114);
        @(posedge i_Clk);
        #1;
        check("late_jalr", o_PC, 32'h0000_8010);

        // Reset held across several edges with enable asserted.
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            check($sformatf("reset_hold_%0d", n), o_PC, 32'h0000_0000);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("release_4", o_PC, 32'h0000_0004);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("release_hold", o_PC, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
